vga_plot_arbiter: RTL and testbench

//   Shares the single VGA adapter write port (plot/x/y/colour) between NUM_REQ sprite drawers.

---
 rtl/vga_plot_arbiter.sv | 116 +++++++++++
 tb/tb_vga_plot_arbiter.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_plot_arbiter.sv
// Round-robin arbiter sharing the single VGA adapter write port between sprite drawers.
// A grant covers a whole redraw burst; a watchdog reclaims the port from a hung drawer.
module vga_plot_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int TIMEOUT = 2048
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic [NUM_REQ-1:0]   req,
   input  logic [NUM_REQ-1:0]   done,
   input  logic [NUM_REQ-1:0]   plot_in,
   input  logic [9*NUM_REQ-1:0] x_in,
   input  logic [8*NUM_REQ-1:0] y_in,
   input  logic [3*NUM_REQ-1:0] colour_in,
   output logic [NUM_REQ-1:0]   grant,
   output logic                 vga_plot,
   output logic [8:0]           vga_x,
   output logic [7:0]           vga_y,
   output logic [2:0]           vga_colour,
   output logic                 timeout
);
   localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT - 1);

   typedef enum logic [1:0] {IDLE, BURST, GAP} stateT;

   stateT         state;
   logic [IW-1:0] rrPtr;
   logic [IW-1:0] owner;
   logic [IW-1:0] winner;
   logic [WW-1:0] wdCnt;
   logic          wdExpired;
   logic          releaseNow;

   logic [8:0] xArr      [NUM_REQ];
   logic [7:0] yArr      [NUM_REQ];
   logic [2:0] colourArr [NUM_REQ];

   genvar gi;
   generate
      for (gi = 0; gi < NUM_REQ; gi++) begin : gUnpack
         assign xArr[gi]      = x_in[9*gi +: 9];
         assign yArr[gi]      = y_in[8*gi +: 8];
         assign colourArr[gi] = colour_in[3*gi +: 3];
      end
   endgenerate

   // Scan from the lowest priority (rrPtr itself) upwards so the slot right after rrPtr wins last.
   always_comb begin
      int idx;
      winner = '0;
      idx    = 0;
      for (int i = NUM_REQ; i >= 1; i--) begin
         idx = int'(rrPtr) + i;
         if (idx >= NUM_REQ) idx = idx - NUM_REQ;
         if (req[IW'(idx)]) winner = IW'(idx);
      end
   end

   assign wdExpired  = (wdCnt == WD_LAST);
   assign releaseNow = done[owner] | ~req[owner] | wdExpired;

   // Only flag the watchdog when it is the sole reason the burst ends.
   assign timeout = (state == BURST) && wdExpired && !done[owner] && req[owner];

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         grant      <= '0;
         rrPtr      <= IW'(NUM_REQ - 1);
         owner      <= '0;
         wdCnt      <= '0;
         vga_plot   <= 1'b0;
         vga_x      <= '0;
         vga_y      <= '0;
         vga_colour <= '0;
      end else begin
         case (state)
            IDLE: begin
               vga_plot <= 1'b0;
               if (|req) begin
                  grant <= NUM_REQ'(1) << winner;
                  rrPtr <= winner;
                  owner <= winner;
                  wdCnt <= '0;
                  state <= BURST;
               end
            end
            BURST: begin
               vga_plot <= plot_in[owner];
               if (plot_in[owner]) begin
                  vga_x      <= xArr[owner];
                  vga_y      <= yArr[owner];
                  vga_colour <= colourArr[owner];
               end
               if (releaseNow) begin
                  grant <= '0;
                  state <= GAP;
               end else begin
                  wdCnt <= wdCnt + 1'b1;
               end
            end
            GAP: begin
               vga_plot <= 1'b0;
               state    <= IDLE;
            end
            default: begin
               grant    <= '0;
               vga_plot <= 1'b0;
               state    <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_vga_plot_arbiter.sv
// Scoreboard bench for vga_plot_arbiter: stimulus queues expected grants, pixels,
// watchdog pulses and output snapshots; a negedge monitor pops and compares them.
module tb_vga_plot_arbiter;
   typedef struct { logic [3:0] g; int c; } grantE;
   typedef struct { logic [8:0] x; logic [7:0] y; logic [2:0] col; int c; } pixE;
   typedef struct {
      int c; logic [3:0] g; logic p; logic [8:0] x; logic [7:0] y; logic [2:0] col; logic to;
   } snapE;

   logic clock = 1'b0;
   logic reset;
   logic [3:0] req, done, plotIn;
   logic [8:0] xs [4];
   logic [7:0] ys [4];
   logic [2:0] cs [4];
   logic [35:0] xBus;
   logic [31:0] yBus;
   logic [11:0] cBus;
   logic [3:0] grant;
   logic vgaPlot, timeout;
   logic [8:0] vgaX;
   logic [7:0] vgaY;
   logic [2:0] vgaColour;

   int cyc = 0;
   int nVec = 0;
   int nMis = 0;
   logic stimDone = 1'b0;

   grantE grantQ [$];
   pixE   pixQ   [$];
   snapE  snapQ  [$];
   int    toQ    [$];

   assign xBus = {xs[3], xs[2], xs[1], xs[0]};
   assign yBus = {ys[3], ys[2], ys[1], ys[0]};
   assign cBus = {cs[3], cs[2], cs[1], cs[0]};

   vga_plot_arbiter #(.NUM_REQ(4), .TIMEOUT(16)) dut (
      .clock(clock), .reset(reset), .req(req), .done(done), .plot_in(plotIn),
      .x_in(xBus), .y_in(yBus), .colour_in(cBus), .grant(grant), .vga_plot(vgaPlot),
      .vga_x(vgaX), .vga_y(vgaY), .vga_colour(vgaColour), .timeout(timeout)
   );

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic expGrant(input logic [3:0] g, input int c);
      grantE e;
      e.g = g; e.c = c;
      grantQ.push_back(e);
   endtask

   task automatic expPix(input logic [8:0] x, input logic [7:0] y, input logic [2:0] col, input int c);
      pixE e;
      e.x = x; e.y = y; e.col = col; e.c = c;
      pixQ.push_back(e);
   endtask

   task automatic expSnap(input int c, input logic [3:0] g, input logic p, input logic [8:0] x,
                          input logic [7:0] y, input logic [2:0] col, input logic to);
      snapE e;
      e.c = c; e.g = g; e.p = p; e.x = x; e.y = y; e.col = col; e.to = to;
      snapQ.push_back(e);
   endtask

   task automatic clearPix();
      for (int i = 0; i < 4; i++) begin
         xs[i] = '0; ys[i] = '0; cs[i] = '0;
      end
   endtask

   // Stimulus
   initial begin
      int order [6];
      int t;
      order = '{0, 1, 3, 0, 1, 3};
      reset = 1'b1; req = '0; done = '0; plotIn = '0;
      clearPix();
      tick(); tick(); tick();
      expSnap(cyc, 4'b0000, 1'b0, 9'd0, 8'd0, 3'd0, 1'b0);
      reset = 1'b0;
      tick();

      // Round-robin with three requesters, each releasing after three cycles
      req = 4'b1011;
      for (int r = 0; r < 6; r++) begin
         t = cyc;
         expGrant(4'(1 << order[r]), t + 1);
         tick();
         tick();
         plotIn = 4'(1 << order[r]);
         xs[order[r]] = 9'(order[r] * 20 + r);
         ys[order[r]] = 8'(r + 1);
         cs[order[r]] = 3'(order[r] + 1);
         expPix(9'(order[r] * 20 + r), 8'(r + 1), 3'(order[r] + 1), t + 3);
         tick();
         plotIn = '0;
         done = 4'(1 << order[r]);
         expGrant(4'b0000, t + 4);
         tick();
         done = '0;
         if (r == 5) req = '0;
         tick();
      end

      // Single burst from drawer 2, done after the last pixel
      req = 4'b0100;
      expGrant(4'b0100, cyc + 1);
      for (int k = 0; k < 5; k++) begin
         tick();
         plotIn = 4'b0100;
         xs[2] = 9'(10 + k); ys[2] = 8'd20; cs[2] = 3'b101;
         expPix(9'(10 + k), 8'd20, 3'b101, cyc + 1);
      end
      tick();
      plotIn = '0; xs[2] = '0; done = 4'b0100;
      expGrant(4'b0000, cyc + 1);
      tick();
      done = '0; req = '0;
      tick();
      expSnap(cyc, 4'b0000, 1'b0, 9'd14, 8'd20, 3'b101, 1'b0);

      // Isolation: drawer 3 scribbles and pulses done while drawer 0 owns the port
      req = 4'b0001; plotIn = 4'b1000;
      xs[3] = 9'd300; ys[3] = 8'd200; cs[3] = 3'd7;
      expGrant(4'b0001, cyc + 1);
      tick();
      plotIn = 4'b1001; xs[0] = 9'd40; ys[0] = 8'd60; cs[0] = 3'd1;
      expPix(9'd40, 8'd60, 3'd1, cyc + 1);
      tick();
      plotIn = 4'b1000; xs[0] = 9'd41; done = 4'b1000;
      tick();
      done = '0; plotIn = 4'b1001; xs[0] = 9'd42;
      expPix(9'd42, 8'd60, 3'd1, cyc + 1);
      tick();
      plotIn = 4'b1000; done = 4'b0001;
      expGrant(4'b0000, cyc + 1);
      tick();
      done = '0; req = '0; plotIn = '0;
      clearPix();
      tick();

      // Asynchronous reset in the middle of drawer 1's burst
      req = 4'b0010;
      expGrant(4'b0010, cyc + 1);
      tick();
      plotIn = 4'b0010; xs[1] = 9'd100; ys[1] = 8'd50; cs[1] = 3'd2;
      expPix(9'd100, 8'd50, 3'd2, cyc + 1);
      tick();
      xs[1] = 9'd101;
      tick();
      reset = 1'b1;
      expGrant(4'b0000, cyc);
      expSnap(cyc, 4'b0000, 1'b0, 9'd0, 8'd0, 3'd0, 1'b0);
      req = '0; plotIn = '0;
      clearPix();
      tick();
      reset = 1'b0; req = 4'b1111;
      expGrant(4'b0001, cyc + 1);
      tick();
      done = 4'b0001;
      expGrant(4'b0000, cyc + 1);
      tick();
      done = '0; req = '0;
      tick();

      // Watchdog: drawer 1 never finishes, drawer 2 waits
      t = cyc;
      req = 4'b0110;
      expGrant(4'b0010, t + 1);
      toQ.push_back(t + 16);
      expGrant(4'b0000, t + 17);
      expGrant(4'b0100, t + 19);
      repeat (17) tick();
      req = 4'b0100;
      tick();
      tick();
      done = 4'b0100;
      expGrant(4'b0000, cyc + 1);
      tick();
      done = '0; req = '0;
      tick();

      // Early release by dropping req, then a final pixel coinciding with done
      t = cyc;
      req = 4'b1001;
      expGrant(4'b1000, t + 1);
      tick();
      plotIn = 4'b1000; xs[3] = 9'd319; ys[3] = 8'd239; cs[3] = 3'd7;
      expPix(9'd319, 8'd239, 3'd7, t + 2);
      tick();
      plotIn = '0; req = 4'b0001;
      expGrant(4'b0000, t + 3);
      expGrant(4'b0001, t + 5);
      tick(); tick(); tick();
      plotIn = 4'b0001; xs[0] = 9'd5; ys[0] = 8'd6; cs[0] = 3'd3; done = 4'b0001;
      expPix(9'd5, 8'd6, 3'd3, t + 6);
      expGrant(4'b0000, t + 6);
      tick();
      plotIn = '0; done = '0; req = '0;
      clearPix();
      repeat (4) tick();
      stimDone = 1'b1;
   end

   // Monitor
   initial begin
      logic [3:0] lastGrant;
      grantE ge;
      pixE pe;
      snapE se;
      int te;
      lastGrant = 4'b0000;
      forever begin
         @(negedge clock);
         if (grant !== lastGrant) begin
            nVec++;
            if (grantQ.size() == 0) begin
               nMis++;
               $display("FAIL grant: unexpected change to %b at cycle %0d", grant, cyc);
            end else begin
               ge = grantQ.pop_front();
               if (grant !== ge.g || cyc != ge.c) begin
                  nMis++;
                  $display("FAIL grant: got %b at cycle %0d, expected %b at cycle %0d", grant, cyc, ge.g, ge.c);
               end
            end
            lastGrant = grant;
         end
         if (vgaPlot !== 1'b0) begin
            nVec++;
            if (pixQ.size() == 0) begin
               nMis++;
               $display("FAIL pixel: unexpected plot=%b x=%0d y=%0d col=%0d at cycle %0d", vgaPlot, vgaX, vgaY, vgaColour, cyc);
            end else begin
               pe = pixQ.pop_front();
               if (vgaX !== pe.x || vgaY !== pe.y || vgaColour !== pe.col || cyc != pe.c) begin
                  nMis++;
                  $display("FAIL pixel: got x=%0d y=%0d col=%0d at cycle %0d, expected x=%0d y=%0d col=%0d at cycle %0d",
                           vgaX, vgaY, vgaColour, cyc, pe.x, pe.y, pe.col, pe.c);
               end
            end
         end
         if (timeout !== 1'b0) begin
            nVec++;
            if (toQ.size() == 0) begin
               nMis++;
               $display("FAIL timeout: unexpected pulse (%b) at cycle %0d", timeout, cyc);
            end else begin
               te = toQ.pop_front();
               if (cyc != te) begin
                  nMis++;
                  $display("FAIL timeout: pulse at cycle %0d, expected cycle %0d", cyc, te);
               end
            end
         end
         if (snapQ.size() > 0 && snapQ[0].c <= cyc) begin
            se = snapQ.pop_front();
            nVec++;
            if (grant !== se.g || vgaPlot !== se.p || vgaX !== se.x || vgaY !== se.y ||
                vgaColour !== se.col || timeout !== se.to || cyc != se.c) begin
               nMis++;
               $display("FAIL snapshot: cycle %0d grant=%b plot=%b x=%0d y=%0d col=%0d to=%b, expected cycle %0d grant=%b plot=%b x=%0d y=%0d col=%0d to=%b",
                        cyc, grant, vgaPlot, vgaX, vgaY, vgaColour, timeout, se.c, se.g, se.p, se.x, se.y, se.col, se.to);
            end
         end
         if (stimDone) begin
            nVec++;
            if (grantQ.size() != 0 || pixQ.size() != 0 || toQ.size() != 0 || snapQ.size() != 0) begin
               nMis++;
               $display("FAIL drain: pending grants=%0d pixels=%0d timeouts=%0d snapshots=%0d, expected all 0",
                        grantQ.size(), pixQ.size(), toQ.size(), snapQ.size());
            end
            $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
            $finish;
         end
      end
   end
endmodule
